// File: rtl/voxel_ram_arbiter_pkg.sv
// Shared voxel-world types: block coordinates, block contents and world extent.
package voxel_ram_arbiter_pkg;

  localparam int WORLD_DIM = 16;
  localparam int COORD_W   = 8;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } BlockPos;

  typedef logic [7:0] BlockType;

  localparam BlockType BLOCK_AIR = 8'h00;

  function automatic logic pos_in_world(BlockPos p);
    return (p.x >= 0) && (p.x < WORLD_DIM) &&
           (p.y >= 0) && (p.y < WORLD_DIM) &&
           (p.z >= 0) && (p.z < WORLD_DIM);
  endfunction

endpackage

// File: rtl/voxel_ram_arbiter_rr_select.sv
// Round-robin pick: first eligible requester at or above ptr_i, wrapping to 0.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Upper segment [ptr, NUM_REQ) first, then the wrapped segment [0, ptr).
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!valid_o && eligible_i[j] && (j >= int'(ptr_i))) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!valid_o && eligible_i[j] && (j < int'(ptr_i))) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/voxel_ram_arbiter.sv
// Round-robin arbiter sharing one fixed-latency voxel RAM among traversal units.
// Optional macro VOXEL_ARB_BOUNDS_EN suppresses RAM reads for out-of-world addresses.
module voxel_ram_arbiter
  import voxel_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  BlockPos [NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_read_enable,
  output BlockType              resp_data,
  output logic [NUM_REQ-1:0]    resp_valid,
  output BlockPos               ram_addr,
  output logic                  ram_read_enable,
  input  BlockType              ram_out,
  output logic                  busy
);

  // Protocol: a requester holds req_read_enable with a stable req_addr; once granted it is
  // blocked until the edge ending its one-cycle resp_valid pulse, which is always delivered.
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] out_q, out_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0] eligible, gnt_oh;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any, gnt_oob;
  BlockPos            gnt_addr;

  BlockPos            ram_addr_q;
  logic               ram_re_q;

  // Tag stage 0 travels with ram_addr; stage RAM_LATENCY lines up with ram_out.
  logic [RAM_LATENCY:0]          tag_v_q;
  logic [RAM_LATENCY:0]          tag_oob_q;
  logic [RAM_LATENCY:0][IDW-1:0] tag_id_q;

  BlockType           resp_data_q;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;

  assign eligible = req_read_enable & ~out_q;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_select (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (gnt_oh),
    .idx_o      (gnt_idx),
    .valid_o    (gnt_any)
  );

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) gnt_addr = req_addr[i];
    end
  end

`ifdef VOXEL_ARB_BOUNDS_EN
  assign gnt_oob = gnt_any && !pos_in_world(gnt_addr);
`else
  assign gnt_oob = 1'b0;
`endif

  always_comb begin
    out_d = (out_q & ~resp_valid_q) | gnt_oh;
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDW'(1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = tag_v_q[RAM_LATENCY] && (tag_id_q[RAM_LATENCY] == IDW'(i));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_q        <= '0;
      ptr_q        <= '0;
      ram_addr_q   <= '0;
      ram_re_q     <= 1'b0;
      tag_v_q      <= '0;
      tag_oob_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= BLOCK_AIR;
    end else begin
      out_q        <= out_d;
      ptr_q        <= ptr_d;
      ram_re_q     <= gnt_any && !gnt_oob;
      if (gnt_any) ram_addr_q <= gnt_addr;
      tag_v_q      <= {tag_v_q[RAM_LATENCY-1:0], gnt_any};
      tag_oob_q    <= {tag_oob_q[RAM_LATENCY-1:0], gnt_oob};
      tag_id_q     <= {tag_id_q[RAM_LATENCY-1:0], gnt_idx};
      resp_valid_q <= resp_valid_d;
      if (tag_v_q[RAM_LATENCY]) begin
        resp_data_q <= tag_oob_q[RAM_LATENCY] ? BLOCK_AIR : ram_out;
      end
    end
  end

  assign ram_addr        = ram_addr_q;
  assign ram_read_enable = ram_re_q;
  assign resp_data       = resp_data_q;
  assign resp_valid      = resp_valid_q;
  assign busy            = |out_q;

endmodule
